// File: rtl/sec_tx.sv
// sec_tx: asynchronous serial transmitter (start / 1-8 data bits LSB first /
// optional parity / 1-2 stop bits), paced by an oversampling tick enable.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        synchronous active-high reset
//   i_tick       oversampling enable, OVS pulses per bit period
//   i_tx_en      enables acceptance of new frames (never aborts a frame)
//   i_tx_start   send request, accepted when i_tx_start && o_tx_ready
//   i_tx_in      data word, captured at acceptance
//   i_tx_len     data bits minus one, captured at acceptance
//   i_par_en     parity bit enable, captured at acceptance
//   i_par_odd    1 = odd parity, 0 = even, captured at acceptance
//   i_stop2      1 = two stop bits, captured at acceptance
//   o_tx         serial line, registered, idle high
//   o_tx_ready   combinational: idle, enabled and not in reset
//   o_tx_busy    registered, high from acceptance until return to idle
//   o_tx_done    registered one-clock pulse at end of the last stop bit
//
// State   | meaning
// --------+---------------------------------------------------------
// IDLE    | line high, waiting for an accepted request
// START   | start bit (low) for OVS counted ticks
// DATA    | data bit r_bit_idx for OVS ticks, bits 0..r_len
// PARITY  | parity over the transmitted data bits for OVS ticks
// STOP    | line high for OVS ticks, twice over when r_stop2

module sec_tx #(
    parameter int OVS = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tick,
    input  logic       i_tx_en,
    input  logic       i_tx_start,
    input  logic [7:0] i_tx_in,
    input  logic [2:0] i_tx_len,
    input  logic       i_par_en,
    input  logic       i_par_odd,
    input  logic       i_stop2,
    output logic       o_tx,
    output logic       o_tx_ready,
    output logic       o_tx_busy,
    output logic       o_tx_done
);

    localparam int CW = $clog2(OVS);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [2:0]      r_bit_idx, w_bit_idx_nxt;
    logic            r_stop_second, w_stop_second_nxt;
    logic [7:0]      r_data, w_data_nxt;
    logic [2:0]      r_len, w_len_nxt;
    logic            r_par_en, w_par_en_nxt;
    logic            r_par_odd, w_par_odd_nxt;
    logic            r_stop2, w_stop2_nxt;
    logic            r_tx, w_tx_nxt;
    logic            r_busy, w_busy_nxt;
    logic            r_done, w_done_nxt;

    logic            w_accept;
    logic            w_bit_end;
    logic [CW-1:0]   w_cnt_step;
    logic [7:0]      w_mask;
    logic            w_par_bit;
    logic [2:0]      w_idx_inc;

    assign o_tx       = r_tx;
    assign o_tx_busy  = r_busy;
    assign o_tx_done  = r_done;
    assign o_tx_ready = (r_state == ST_IDLE) && i_tx_en && !i_rst;

    assign w_accept   = (r_state == ST_IDLE) && i_tx_en && i_tx_start;
    assign w_bit_end  = i_tick && (r_cnt == CNT_LAST);
    assign w_cnt_step = w_bit_end ? '0 : r_cnt + CW'(1);
    assign w_idx_inc  = r_bit_idx + 3'd1;

    // Only bits 0..r_len take part in the parity; higher bits are never sent.
    assign w_mask     = 8'hFF >> (3'd7 - r_len);
    assign w_par_bit  = (^(r_data & w_mask)) ^ r_par_odd;

    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_bit_idx_nxt     = r_bit_idx;
        w_stop_second_nxt = r_stop_second;
        w_data_nxt        = r_data;
        w_len_nxt         = r_len;
        w_par_en_nxt      = r_par_en;
        w_par_odd_nxt     = r_par_odd;
        w_stop2_nxt       = r_stop2;
        w_tx_nxt          = r_tx;
        w_busy_nxt        = r_busy;
        w_done_nxt        = 1'b0;

        if (r_state != ST_IDLE && i_tick) begin
            w_cnt_nxt = w_cnt_step;
        end

        case (r_state)
            ST_IDLE: begin
                // A tick coinciding with acceptance is not counted.
                w_cnt_nxt     = '0;
                w_bit_idx_nxt = '0;
                w_tx_nxt      = 1'b1;
                if (w_accept) begin
                    w_data_nxt        = i_tx_in;
                    w_len_nxt         = i_tx_len;
                    w_par_en_nxt      = i_par_en;
                    w_par_odd_nxt     = i_par_odd;
                    w_stop2_nxt       = i_stop2;
                    w_stop_second_nxt = 1'b0;
                    w_state_nxt       = ST_START;
                    w_tx_nxt          = 1'b0;
                    w_busy_nxt        = 1'b1;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_nxt   = ST_DATA;
                    w_bit_idx_nxt = '0;
                    w_tx_nxt      = r_data[0];
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == r_len) begin
                        if (r_par_en) begin
                            w_state_nxt = ST_PARITY;
                            w_tx_nxt    = w_par_bit;
                        end else begin
                            w_state_nxt = ST_STOP;
                            w_tx_nxt    = 1'b1;
                        end
                    end else begin
                        w_bit_idx_nxt = w_idx_inc;
                        w_tx_nxt      = r_data[w_idx_inc];
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = ST_STOP;
                    w_tx_nxt    = 1'b1;
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    if (r_stop2 && !r_stop_second) begin
                        w_stop_second_nxt = 1'b1;
                    end else begin
                        w_state_nxt   = ST_IDLE;
                        w_bit_idx_nxt = '0;
                        w_tx_nxt      = 1'b1;
                        w_busy_nxt    = 1'b0;
                        w_done_nxt    = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_tx_nxt    = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_bit_idx     <= '0;
            r_stop_second <= 1'b0;
            r_data        <= '0;
            r_len         <= '0;
            r_par_en      <= 1'b0;
            r_par_odd     <= 1'b0;
            r_stop2       <= 1'b0;
            r_tx          <= 1'b1;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_bit_idx     <= w_bit_idx_nxt;
            r_stop_second <= w_stop_second_nxt;
            r_data        <= w_data_nxt;
            r_len         <= w_len_nxt;
            r_par_en      <= w_par_en_nxt;
            r_par_odd     <= w_par_odd_nxt;
            r_stop2       <= w_stop2_nxt;
            r_tx          <= w_tx_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_sec_tx.sv
// Testbench for sec_tx. Each accepted frame pushes its expected line level,
// one entry per oversampling tick, onto a scoreboard queue; the line monitor
// pops one entry for every tick seen while the transmitter is busy.

module tb_sec_tx;

    localparam int OVS = 16;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       tx_en;
    logic       tx_start;
    logic [7:0] tx_in;
    logic [2:0] tx_len;
    logic       par_en;
    logic       par_odd;
    logic       stop2;
    logic       tx;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;

    int total;
    int bad;
    int done_cnt;
    int exp_done;
    bit mon_en;
    logic sb_q[$];

    sec_tx #(.OVS(OVS)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_tick     (tick),
        .i_tx_en    (tx_en),
        .i_tx_start (tx_start),
        .i_tx_in    (tx_in),
        .i_tx_len   (tx_len),
        .i_par_en   (par_en),
        .i_par_odd  (par_odd),
        .i_stop2    (stop2),
        .o_tx       (tx),
        .o_tx_ready (tx_ready),
        .o_tx_busy  (tx_busy),
        .o_tx_done  (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One tick every four clocks.
    initial begin
        logic [1:0] ph;
        ph   = 2'd0;
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ph   = ph + 2'd1;
            tick = (ph == 2'd0);
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_bit(input logic b);
        repeat (OVS) sb_q.push_back(b);
    endtask

    task automatic push_frame(input logic [7:0] d, input logic [2:0] len,
                              input logic pe, input logic po, input logic s2);
        logic p;
        p = po;
        push_bit(1'b0);
        for (int i = 0; i <= int'(len); i++) begin
            push_bit(d[i]);
            p = p ^ d[i];
        end
        if (pe) push_bit(p);
        push_bit(1'b1);
        if (s2) push_bit(1'b1);
        exp_done++;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (tx_busy === 1'b1 && tick) begin
                if (sb_q.size() == 0) chk("sb_underflow", 32'(sb_q.size()), 32'd1);
                else chk("tx_bit", 32'(tx), 32'(sb_q.pop_front()));
            end
            if (tx_busy === 1'b0 && tick) chk("tx_idle", 32'(tx), 32'd1);
            if (tx_done === 1'b1) begin
                done_cnt++;
                chk("frame_end", 32'(sb_q.size()), 32'd0);
                chk("busy_at_done", 32'(tx_busy), 32'd0);
            end
        end
    end

    task automatic start_frame(input logic [7:0] d, input logic [2:0] len,
                               input logic pe, input logic po, input logic s2);
        @(posedge clk);
        #1;
        tx_in    = d;
        tx_len   = len;
        par_en   = pe;
        par_odd  = po;
        stop2    = s2;
        tx_start = 1'b1;
        chk("ready_before", 32'(tx_ready), 32'd1);
        push_frame(d, len, pe, po, s2);
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        chk("busy_after_acc", 32'(tx_busy), 32'd1);
        chk("tx_start_bit", 32'(tx), 32'd0);
        chk("ready_after_acc", 32'(tx_ready), 32'd0);
    endtask

    task automatic wait_ticks(input int n);
        int k;
        k = 0;
        while (k < n) begin
            @(negedge clk);
            if (tick) k++;
        end
    endtask

    task automatic wait_done(input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (tx_done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk({tag, "_timeout"}, 32'd0, 32'd1);
        @(posedge clk);
        #1;
        chk({tag, "_done_cnt"}, 32'(done_cnt), 32'(exp_done));
        chk({tag, "_done_pulse"}, 32'(tx_done), 32'd0);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        done_cnt = 0;
        exp_done = 0;
        mon_en   = 1'b0;
        rst      = 1'b1;
        tx_en    = 1'b1;
        tx_start = 1'b0;
        tx_in    = 8'h00;
        tx_len   = 3'd0;
        par_en   = 1'b0;
        par_odd  = 1'b0;
        stop2    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_done", 32'(tx_done), 32'd0);
        chk("rst_ready", 32'(tx_ready), 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;
        #1;
        chk("ready_idle", 32'(tx_ready), 32'd1);

        // 8N1, alternating pattern
        start_frame(8'h55, 3'd7, 1'b0, 1'b0, 1'b0);
        wait_done("f55");

        // 7 bits with even and odd parity, back to back
        start_frame(8'h41, 3'd6, 1'b1, 1'b0, 1'b0);
        wait_done("par_even");
        start_frame(8'h41, 3'd6, 1'b1, 1'b1, 1'b0);
        wait_done("par_odd");

        // 5 bits, two stop bits; upper ones never sent
        start_frame(8'hFF, 3'd4, 1'b0, 1'b0, 1'b1);
        wait_done("stop2");

        // single data bit with odd parity and two stops
        start_frame(8'hFE, 3'd0, 1'b1, 1'b1, 1'b1);
        wait_done("len1");

        // Inputs changed, start re-pulsed and enable dropped mid-frame
        start_frame(8'hA6, 3'd7, 1'b1, 1'b0, 1'b0);
        wait_ticks(40);
        @(posedge clk);
        #1;
        tx_in    = 8'h00;
        tx_len   = 3'd0;
        par_en   = 1'b0;
        stop2    = 1'b1;
        tx_start = 1'b1;
        chk("ready_mid", 32'(tx_ready), 32'd0);
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        wait_ticks(30);
        tx_en = 1'b0;
        wait_done("mid");
        chk("ready_en_off", 32'(tx_ready), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        chk("no_second_frame", 32'(done_cnt), 32'(exp_done));
        tx_en = 1'b1;

        // Reset during data bit 3
        start_frame(8'h3C, 3'd7, 1'b0, 1'b0, 1'b0);
        wait_ticks(OVS + 3 * OVS + 5);
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("ready_in_rst", 32'(tx_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("mid_rst_tx", 32'(tx), 32'd1);
        chk("mid_rst_busy", 32'(tx_busy), 32'd0);
        chk("mid_rst_done", 32'(tx_done), 32'd0);
        rst = 1'b0;
        sb_q.delete();
        exp_done--;
        repeat (100) @(posedge clk);
        #1;
        chk("no_done_after_rst", 32'(done_cnt), 32'(exp_done));
        start_frame(8'hC3, 3'd7, 1'b1, 1'b0, 1'b1);
        wait_done("after_rst");

        // Disabled transmitter ignores a held request
        @(posedge clk);
        #1;
        tx_en    = 1'b0;
        tx_start = 1'b1;
        for (int k = 0; k < 100; ) begin
            @(negedge clk);
            if (tick) begin
                k++;
                if (k % 20 == 0) begin
                    chk("dis_ready", 32'(tx_ready), 32'd0);
                    chk("dis_busy", 32'(tx_busy), 32'd0);
                end
            end
        end
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        tx_en    = 1'b1;
        chk("dis_no_frame", 32'(done_cnt), 32'(exp_done));
        chk("dis_tx", 32'(tx), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sec_tx.md
# sec_tx

Serial transmitter that serialises one parallel word per frame onto the asynchronous line `tx`. It is the transmit end of the same start/data/stop link the receiver decodes, and runs off the same oversampling `tick` enable. It supports:
- 1–8 data bits, sent LSB first;
- optional even/odd parity;
- 1 or 2 stop bits.

It sits between the system-side producer (ready/start handshake) and the line driver.

## Interface
Parameters:
- OVS, 16, ticks per bit period (≥2); counter width = clog2(OVS)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- tick  in  1  oversampling enable, one-clk pulse, OVS per bit period
- txEn  in  1  transmitter enable; gates acceptance of new frames only
- txStart  in  1  request to send; accepted when txStart && txReady
- txIn  in  8  data word, sampled at acceptance
- txLen  in  3  data bits = txLen+1 (1..8), sampled at acceptance
- parEn  in  1  parity bit enable, sampled at acceptance
- parOdd  in  1  1 = odd parity, 0 = even, sampled at acceptance
- stop2  in  1  1 = two stop bits, sampled at acceptance
- tx  out  1  serial line, registered, idle high
- txReady  out  1  combinational: (state==IDLE) && txEn && !rst
- txBusy  out  1  registered, high from the cycle after acceptance until return to IDLE
- txDone  out  1  registered one-clk pulse at end of last stop bit

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- **IDLE**
  - tx=1, tick counter and bit index held at 0.
  - On accept, latch txIn/txLen/parEn/parOdd/stop2 into shadow registers and go to START.
  - Later changes on those inputs have no effect on the frame in progress.
- **START**: tx=0 for OVS ticks, then DATA with bit index 0.
- **DATA**
  - tx = data[bitIdx] for OVS ticks each.
  - After bit txLen, go to PARITY if parEn, else STOP.
  - Bits above txLen are never sent.
- **PARITY**
  - Even: tx = XOR of the transmitted data bits (bits 0..txLen).
  - Odd: tx = the inverse of that XOR.
  - Lasts OVS ticks, then STOP.
- **STOP**
  - tx=1 for OVS ticks, or 2·OVS ticks if stop2.
  - Then pulse txDone, clear txBusy and return to IDLE.
- Bit timing: the counter increments on each clk where tick=1. When tick=1 and counter==OVS-1, the counter wraps to 0 and the bit or state advances on that edge.
- Frame length = OVS·(2 + txLen + parEn + 1 + stop2) ticks.
- txStart is ignored outside IDLE or while txEn=0. There is no queuing.
- Deasserting txEn mid-frame does not abort the frame; only the next acceptance is blocked.
- rst=1 at any time, including mid-frame: at the next edge go to IDLE, tx=1, txBusy=0, txDone=0, counters=0, shadow registers=0. Any partial frame is abandoned.

## Timing
- Reset values: tx=1, txBusy=0, txDone=0; txReady=0 while rst=1.
- Acceptance edge (txStart && txReady): state becomes START and txBusy=1. tx reflects START (0) on the following cycle.
- The first start bit lasts OVS counted ticks after acceptance. Its wall-clock width is OVS-1 to OVS tick periods, depending on tick phase. All later bits are exactly OVS tick periods.
- tx changes only on edges where the current bit completes (tick=1, counter=OVS-1), apart from the acceptance transition.
- txDone is high for exactly one clk, on the edge that returns to IDLE. txReady can be high in the next cycle (if txEn=1).
- Back-to-back frames: minimum gap between txDone and the next start bit is one clk. The line stays high during that gap.
- tick and txStart in the same cycle in IDLE: the frame is accepted, and that tick does not count toward the start bit.

## Test plan
- OVS=16, txLen=7, parEn=0, stop2=0, txIn=0x55:
  - tx = 0, then 1,0,1,0,1,0,1,0, then 1, each 16 ticks; 160 ticks total.
  - One txDone pulse; txBusy high throughout.
- txLen=6, parEn=1, txIn=0x41:
  - Even parity: parity bit = 0.
  - Repeat with parOdd=1: parity bit = 1.
  - Frame = 10 bits = 160 ticks.
- txLen=4, stop2=1, txIn=0xFF:
  - Exactly five 1 data bits, then two stop bits.
  - Frame = 8 bits = 128 ticks; tx=1 after start.
- Mid-frame behaviour:
  - Change txIn to 0x00 and pulse txStart during DATA: waveform unchanged, no second frame.
  - Drop txEn mid-frame: frame completes normally.
- Assert rst for 1 clk at data bit 3: next edge tx=1, txBusy=0, no txDone. A new txStart after reset sends a complete, correct frame.
- txEn=0 with txStart held high for 100 ticks: txReady=0, tx stays 1, txBusy stays 0.
